// File: rtl/monster_path_sched.sv
// Round-robin scheduler sharing one shortest-path engine among N_MON chasers.
// Latches each engine result into a per-monster dir/dist register and pulses upd.
module monster_path_sched #(
   parameter int unsigned N_MON    = 4,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned DIST_INF = 1023
) (
   input  logic                  clk_13,
   input  logic                  rst,
   input  logic [2:0]            map_idx,
   input  logic [N_MON-1:0]      mon_req,
   input  logic [10*N_MON-1:0]   mon_r,
   input  logic [10*N_MON-1:0]   mon_c,
   output logic                  q_valid,
   input  logic                  q_ready,
   output logic [9:0]            q_r,
   output logic [9:0]            q_c,
   input  logic                  resp_valid,
   input  logic [2:0]            resp_dir,
   input  logic [9:0]            resp_dist,
   output logic [3*N_MON-1:0]    dir_out,
   output logic [10*N_MON-1:0]   dist_out,
   output logic [N_MON-1:0]      upd,
   output logic                  busy
);

   localparam int unsigned PW = (N_MON > 1) ? $clog2(N_MON) : 1;
   localparam logic [9:0] INF10 = 10'(DIST_INF);
   localparam logic [10*N_MON-1:0] DIST_ALL = {N_MON{INF10}};
   localparam logic [2:0] MOVE_STOP = 3'd0;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        rr_q;
   logic [PW-1:0]        gnt_q;
   logic [PW-1:0]        gnt_idx;
   logic                 gnt_found;
   logic [9:0]           q_r_q, q_c_q;
   logic [3*N_MON-1:0]   dir_q;
   logic [10*N_MON-1:0]  dist_q;
   logic [N_MON-1:0]     upd_q;
   logic [9:0]           timer_q;
   logic [2:0]           map_q;
   logic                 flush;
   logic                 wr_en;
   logic [2:0]           wr_dir;
   logic [9:0]           wr_dist;

   assign flush = (map_idx != map_q);

   // Search starts at rr_q and wraps by compare so non-power-of-2 N_MON works.
   always_comb begin : grant_search
      int unsigned idx;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned off = 0; off < N_MON; off++) begin
         idx = int'(rr_q) + off;
         if (idx >= N_MON) idx = idx - N_MON;
         if (!gnt_found && mon_req[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      wr_dir  = MOVE_STOP;
      wr_dist = INF10;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (q_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (resp_valid) begin
               wr_en   = 1'b1;
               wr_dir  = (resp_dir > 3'd4) ? MOVE_STOP : resp_dir;
               wr_dist = resp_dist;
               state_d = ST_IDLE;
            end else if (timer_q == 10'(TIMEOUT)) begin
               wr_en   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A map change discards everything, including a same-cycle result.
      if (flush) begin
         state_d = ST_IDLE;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk_13 or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         gnt_q   <= '0;
         q_r_q   <= '0;
         q_c_q   <= '0;
         dir_q   <= '0;
         dist_q  <= DIST_ALL;
         upd_q   <= '0;
         timer_q <= '0;
         map_q   <= map_idx;
      end else begin
         state_q <= state_d;
         map_q   <= map_idx;
         upd_q   <= '0;
         if (flush) begin
            dir_q  <= '0;
            dist_q <= DIST_ALL;
         end else begin
            if (state_q == ST_IDLE && gnt_found) begin
               gnt_q <= gnt_idx;
               q_r_q <= mon_r[10*gnt_idx +: 10];
               q_c_q <= mon_c[10*gnt_idx +: 10];
            end
            if (state_q == ST_ISSUE && q_ready) timer_q <= '0;
            else if (state_q == ST_WAIT)        timer_q <= timer_q + 10'd1;
            if (wr_en) begin
               dir_q[3*gnt_q +: 3]   <= wr_dir;
               dist_q[10*gnt_q +: 10] <= wr_dist;
               upd_q[gnt_q]          <= 1'b1;
               rr_q <= (gnt_q == PW'(N_MON-1)) ? '0 : gnt_q + 1'b1;
            end
         end
      end
   end

   assign q_valid  = (state_q == ST_ISSUE) && !flush;
   assign q_r      = q_r_q;
   assign q_c      = q_c_q;
   assign dir_out  = dir_q;
   assign dist_out = dist_q;
   assign upd      = upd_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_monster_path_sched.sv
// Bench for monster_path_sched: directed and random transactions checked
// against a transaction-level round-robin model.
module tb_monster_path_sched;

   localparam int N   = 4;
   localparam int TO  = 8;
   localparam int INF = 1023;

   logic        clk_13 = 1'b0;
   logic        rst;
   logic [2:0]  map_idx;
   logic [N-1:0] mon_req;
   logic [10*N-1:0] mon_r, mon_c;
   logic        q_valid, q_ready;
   logic [9:0]  q_r, q_c;
   logic        resp_valid;
   logic [2:0]  resp_dir;
   logic [9:0]  resp_dist;
   logic [3*N-1:0]  dir_out;
   logic [10*N-1:0] dist_out;
   logic [N-1:0] upd;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int m_rr;
   logic [2:0] m_dir[N];
   logic [9:0] m_dist[N];

   monster_path_sched #(.N_MON(N), .TIMEOUT(TO), .DIST_INF(INF)) dut (
      .clk_13(clk_13), .rst(rst), .map_idx(map_idx), .mon_req(mon_req),
      .mon_r(mon_r), .mon_c(mon_c), .q_valid(q_valid), .q_ready(q_ready),
      .q_r(q_r), .q_c(q_c), .resp_valid(resp_valid), .resp_dir(resp_dir),
      .resp_dist(resp_dist), .dir_out(dir_out), .dist_out(dist_out),
      .upd(upd), .busy(busy)
   );

   always #5 clk_13 = ~clk_13;

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_13);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_dir[i]  = 3'd0;
         m_dist[i] = 10'(INF);
      end
   endtask

   task automatic chk_regs(input string tag);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_dir%0d", tag, i), 64'(dir_out[3*i +: 3]), 64'(m_dir[i]));
         chk($sformatf("%s_dist%0d", tag, i), 64'(dist_out[10*i +: 10]), 64'(m_dist[i]));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_qv"}, 64'(q_valid), 64'd0);
      chk({tag, "_qr"}, 64'(q_r), 64'd0);
      chk({tag, "_qc"}, 64'(q_c), 64'd0);
      chk({tag, "_upd"}, 64'(upd), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk_regs(tag);
   endtask

   // Distinct rows/cols per monster so a wrong grant shows up on q_r/q_c.
   task automatic rand_pos();
      for (int i = 0; i < N; i++) begin
         mon_r[10*i +: 10] = 10'(i*100 + $urandom_range(0, 99));
         mon_c[10*i +: 10] = 10'(i*100 + 500 + $urandom_range(0, 99));
      end
   endtask

   // kind 0: normal; 1: map flush at WAIT cycle kj; 2: rst at WAIT cycle kj.
   task automatic run_txn(input logic [N-1:0] req, input int qd, input int rd,
                          input logic [2:0] rdir, input logic [9:0] rdist,
                          input int kj, input int kind);
      int g;
      logic [9:0] er, ec;
      chk("pre_busy", 64'(busy), 64'd0);
      mon_req = req;
      if (req == '0) begin
         step();
         chk("noreq_busy", 64'(busy), 64'd0);
         chk("noreq_upd", 64'(upd), 64'd0);
         return;
      end
      g = -1;
      for (int off = 0; off < N; off++)
         if (g < 0 && req[(m_rr + off) % N]) g = (m_rr + off) % N;
      er = mon_r[10*g +: 10];
      ec = mon_c[10*g +: 10];
      step();
      chk("issue_qv", 64'(q_valid), 64'd1);
      chk("issue_qr", 64'(q_r), 64'(er));
      chk("issue_qc", 64'(q_c), 64'(ec));
      chk("issue_upd", 64'(upd), 64'd0);
      chk("issue_busy", 64'(busy), 64'd1);
      for (int i = 0; i <= qd; i++) begin
         q_ready    = (i == qd);
         rand_pos();
         mon_req    = req & N'($urandom);
         resp_valid = 1'($urandom);
         resp_dir   = 3'($urandom);
         resp_dist  = 10'($urandom);
         step();
         resp_valid = 1'b0;
         if (i < qd) begin
            chk("hold_qv", 64'(q_valid), 64'd1);
            chk("hold_qr", 64'(q_r), 64'(er));
            chk("hold_qc", 64'(q_c), 64'(ec));
            chk("hold_upd", 64'(upd), 64'd0);
         end
      end
      q_ready = 1'b0;
      chk("wait_qv", 64'(q_valid), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      for (int j = 0; j <= TO; j++) begin
         if (kind == 1 && j == kj) begin
            map_idx    = map_idx + 3'd1;
            resp_valid = 1'b1;
            resp_dir   = rdir;
            resp_dist  = rdist;
            step();
            model_clear();
            chk("flush_upd", 64'(upd), 64'd0);
            chk("flush_busy", 64'(busy), 64'd0);
            chk("flush_qv", 64'(q_valid), 64'd0);
            chk_regs("flush");
            mon_req = '0;
            step();
            resp_valid = 1'b0;
            chk("late_upd", 64'(upd), 64'd0);
            chk("late_busy", 64'(busy), 64'd0);
            chk_regs("late");
            return;
         end
         if (kind == 2 && j == kj) begin
            rst = 1'b1;
            #1;
            model_clear();
            m_rr = 0;
            chk_reset_vals("rst_async");
            step();
            rst        = 1'b0;
            mon_req    = '0;
            resp_valid = 1'b1;
            resp_dir   = rdir;
            resp_dist  = rdist;
            step();
            resp_valid = 1'b0;
            chk_reset_vals("rst_after");
            return;
         end
         resp_valid = (j == rd);
         resp_dir   = (j == rd) ? rdir : 3'($urandom);
         resp_dist  = (j == rd) ? rdist : 10'($urandom);
         step();
         resp_valid = 1'b0;
         if (j == rd || j == TO) begin
            m_dir[g]  = (j == rd && rdir <= 3'd4) ? rdir : 3'd0;
            m_dist[g] = (j == rd) ? rdist : 10'(INF);
            m_rr      = (g + 1) % N;
            chk("done_upd", 64'(upd), 64'(N'(1) << g));
            chk("done_busy", 64'(busy), 64'd0);
            chk_regs("done");
            mon_req = '0;
            return;
         end
         chk("wait_upd", 64'(upd), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1; map_idx = 3'd0; mon_req = '0; q_ready = 1'b0;
      resp_valid = 1'b0; resp_dir = '0; resp_dist = '0;
      rand_pos();
      model_clear();
      m_rr = 0;
      step(); step();
      rst = 1'b0;
      chk_reset_vals("reset");

      // single request, best-case latency, mon0 at (1,14)
      mon_r[9:0] = 10'd1;
      mon_c[9:0] = 10'd14;
      run_txn(4'b0001, 0, 0, 3'd3, 10'd7, -1, 0);

      // all requesting: strict rotation
      for (int k = 0; k < 5; k++) begin
         rand_pos();
         run_txn(4'b1111, $urandom_range(0, 2), $urandom_range(0, 3),
                 3'($urandom_range(0, 4)), 10'($urandom), -1, 0);
      end

      // pointer at 3 with requests 0 and 2: wraps to 0, then 2
      rand_pos(); run_txn(4'b0100, 0, 1, 3'd1, 10'd20, -1, 0);
      rand_pos(); run_txn(4'b0101, 0, 1, 3'd2, 10'd21, -1, 0);
      rand_pos(); run_txn(4'b0101, 1, 0, 3'd4, 10'd22, -1, 0);

      // timeout and its boundaries
      rand_pos(); run_txn(4'b0010, 0, TO + 3, 3'd1, 10'd5, -1, 0);
      rand_pos(); run_txn(4'b1000, 0, TO, 3'd2, 10'd6, -1, 0);
      rand_pos(); run_txn(4'b0001, 0, TO - 1, 3'd7, 10'd9, -1, 0);

      // map change during WAIT
      rand_pos(); run_txn(4'b0110, 0, 99, 3'd3, 10'd44, 2, 1);

      // long q_ready stall, then reset in the middle of WAIT
      rand_pos(); run_txn(4'b1000, 20, 2, 3'd4, 10'd100, -1, 0);
      rand_pos(); run_txn(4'b0001, 1, 99, 3'd2, 10'd3, 3, 2);

      for (int k = 0; k < 60; k++) begin
         rand_pos();
         run_txn(N'($urandom), $urandom_range(0, 3), $urandom_range(0, TO + 2),
                 3'($urandom), 10'($urandom), -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
